obi_instr_data_arbiter: RTL and testbench

Shares one downstream OBI memory port between the cv32e40p instruction-fetch and data OBI interfaces. It arbitrates requests round-robin and holds the downstream request stable until it is granted. It tracks up to MAX_OUTSTANDING in-flight transactions in an in-order owner FIFO and steers each rvalid/rdata/err back to the requester that issued it. It sits between the core top and a single-port memory or bus model.

---
 rtl/obi_arb_pkg.sv | 8 +
 rtl/obi_owner_fifo.sv | 63 ++++++
 rtl/obi_instr_data_arbiter.sv | 137 +++++++++++++
 tb/tb_obi_instr_data_arbiter.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_arb_pkg.sv
// Shared types for the instruction/data OBI arbiter: requester identity and lock state.
package obi_arb_pkg;

  typedef enum logic {OWNER_INSTR = 1'b0, OWNER_DATA = 1'b1} owner_e;

  typedef enum logic {ARB_UNLOCKED = 1'b0, ARB_LOCKED = 1'b1} arb_state_e;

endpackage

// File: rtl/obi_owner_fifo.sv
// In-order FIFO of 1-bit owner tags, one entry per in-flight downstream transaction.
module obi_owner_fifo
  import obi_arb_pkg::*;
#(
  parameter int unsigned  DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          reset,
  input  logic          push_i,
  input  owner_e        push_owner_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output owner_e        head_o
);

  localparam int unsigned    PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]  LAST_IDX = PW'(DEPTH - 1);

  logic          tag_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = owner_e'(tag_q[rptr_q]);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Explicit wrap compare keeps non-power-of-two depths correct.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = (wptr_q == LAST_IDX) ? '0 : wptr_q + PW'(1);
    if (do_pop)  rptr_d = (rptr_q == LAST_IDX) ? '0 : rptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) tag_q[wptr_q] <= push_owner_i;
  end

endmodule

// File: rtl/obi_instr_data_arbiter.sv
// Shares one downstream OBI port between fetch and data requesters: round-robin with a
// hold-until-granted lock, and in-order steering of responses back to the issuing side.
module obi_instr_data_arbiter
  import obi_arb_pkg::*;
#(
  parameter int unsigned  MAX_OUTSTANDING = 2,
  parameter int unsigned  AW              = 32,
  parameter int unsigned  DW              = 32,
  localparam int unsigned CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic            clk_i,
  input  logic            reset,
  input  logic            instr_req_i,
  output logic            instr_gnt_o,
  input  logic [AW-1:0]   instr_addr_i,
  output logic            instr_rvalid_o,
  output logic [DW-1:0]   instr_rdata_o,
  output logic            instr_err_o,
  input  logic            data_req_i,
  output logic            data_gnt_o,
  input  logic            data_we_i,
  input  logic [DW/8-1:0] data_be_i,
  input  logic [AW-1:0]   data_addr_i,
  input  logic [DW-1:0]   data_wdata_i,
  output logic            data_rvalid_o,
  output logic [DW-1:0]   data_rdata_o,
  output logic            data_err_o,
  output logic            mem_req_o,
  input  logic            mem_gnt_i,
  output logic [AW-1:0]   mem_addr_o,
  output logic            mem_we_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic            mem_rvalid_i,
  input  logic [DW-1:0]   mem_rdata_i,
  input  logic            mem_err_i,
  output logic [CW-1:0]   outstanding_o,
  output logic            proto_err_o
);

  arb_state_e state_q, state_d;
  owner_e     locked_owner_q, locked_owner_d;
  owner_e     last_owner_q, last_owner_d;
  logic       proto_err_q, proto_err_d;
  owner_e     owner, head;
  logic       owner_req, fifo_full, fifo_empty, push, pop;

  always_comb begin
    if (state_q == ARB_LOCKED)           owner = locked_owner_q;
    else if (instr_req_i && !data_req_i) owner = OWNER_INSTR;
    else if (data_req_i && !instr_req_i) owner = OWNER_DATA;
    else owner = (last_owner_q == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
  end

  assign owner_req = (owner == OWNER_DATA) ? data_req_i : instr_req_i;
  assign mem_req_o = owner_req && !fifo_full && !reset;

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (!reset) begin
      if (owner == OWNER_DATA) begin
        mem_addr_o  = data_addr_i;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_addr_o  = instr_addr_i;
        mem_be_o    = '1;
      end
    end
  end

  assign push        = mem_req_o && mem_gnt_i;
  assign instr_gnt_o = push && (owner == OWNER_INSTR);
  assign data_gnt_o  = push && (owner == OWNER_DATA);

  // A response with nothing in flight is dropped and flagged rather than popped.
  assign pop            = mem_rvalid_i && !fifo_empty;
  assign instr_rvalid_o = pop && (head == OWNER_INSTR);
  assign data_rvalid_o  = pop && (head == OWNER_DATA);
  assign instr_err_o    = instr_rvalid_o && mem_err_i;
  assign data_err_o     = data_rvalid_o && mem_err_i;
  assign instr_rdata_o  = reset ? '0 : mem_rdata_i;
  assign data_rdata_o   = reset ? '0 : mem_rdata_i;
  assign proto_err_o    = proto_err_q;

  always_comb begin
    state_d        = state_q;
    locked_owner_d = locked_owner_q;
    last_owner_d   = push ? owner : last_owner_q;
    proto_err_d    = proto_err_q || (mem_rvalid_i && fifo_empty);
    case (state_q)
      ARB_UNLOCKED: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_d        = ARB_LOCKED;
          locked_owner_d = owner;
        end
      end
      ARB_LOCKED: begin
        if (push) state_d = ARB_UNLOCKED;
      end
      default: state_d = ARB_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q        <= ARB_UNLOCKED;
      locked_owner_q <= OWNER_INSTR;
      last_owner_q   <= OWNER_INSTR;
      proto_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      locked_owner_q <= locked_owner_d;
      last_owner_q   <= last_owner_d;
      proto_err_q    <= proto_err_d;
    end
  end

  obi_owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk_i       (clk_i),
    .reset       (reset),
    .push_i      (push),
    .push_owner_i(owner),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (outstanding_o),
    .head_o      (head)
  );

endmodule

// File: tb/tb_obi_instr_data_arbiter.sv
// Directed scenarios plus a randomized run checked against a queue-based reference model.
module tb_obi_instr_data_arbiter;

  localparam int MAXO = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int CW   = $clog2(MAXO + 1);

  logic            clk_i = 1'b0;
  logic            reset = 1'b1;
  logic            instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [AW-1:0]   instr_addr_i;
  logic [DW-1:0]   instr_rdata_o;
  logic            data_req_i, data_gnt_o, data_we_i, data_rvalid_o, data_err_o;
  logic [DW/8-1:0] data_be_i;
  logic [AW-1:0]   data_addr_i;
  logic [DW-1:0]   data_wdata_i, data_rdata_o;
  logic            mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, mem_err_i;
  logic [AW-1:0]   mem_addr_o;
  logic [DW/8-1:0] mem_be_o;
  logic [DW-1:0]   mem_wdata_o, mem_rdata_i;
  logic [CW-1:0]   outstanding_o;
  logic            proto_err_o;

  int tests_run    = 0;
  int tests_failed = 0;

  obi_instr_data_arbiter #(.MAX_OUTSTANDING(MAXO), .AW(AW), .DW(DW)) dut (
    .clk_i(clk_i), .reset(reset),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .outstanding_o(outstanding_o), .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    instr_req_i = 1'b0; instr_addr_i = '0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF; mem_err_i = 1'b1;
    instr_addr_i = 32'h1234_5678; data_addr_i = 32'h8765_4320;
    for (int k = 0; k < 2; k++) begin
      mid();
      tests_run++;
      if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o,
           instr_err_o, data_err_o, proto_err_o} !== 8'h00) begin
        tests_failed++;
        $display("FAIL reset_ctrl: got req/gnt/rvalid/err/proto=%b required 00000000",
                 {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o,
                  instr_err_o, data_err_o, proto_err_o});
      end
      tests_run++;
      if ({outstanding_o, mem_addr_o, instr_rdata_o, data_rdata_o} !== '0) begin
        tests_failed++;
        $display("FAIL reset_data: got outstanding=%0d addr=%h irdata=%h drdata=%h required all 0",
                 outstanding_o, mem_addr_o, instr_rdata_o, data_rdata_o);
      end
      tick();
    end
    idle_inputs();
    reset = 1'b0;
    $display("[TB] txn reset: outputs held at zero");
  endtask

  task automatic test_single_fetch();
    apply_reset();
    instr_req_i = 1'b1; instr_addr_i = 32'h1A00_0080; mem_gnt_i = 1'b1;
    mid();
    tests_run++;
    if ({instr_gnt_o, data_gnt_o, mem_req_o, mem_addr_o, mem_we_o, mem_be_o, outstanding_o} !==
        {1'b1, 1'b0, 1'b1, 32'h1A00_0080, 1'b0, 4'hF, CW'(0)}) begin
      tests_failed++;
      $display("FAIL fetch_grant: got igat=%b dgnt=%b req=%b addr=%h we=%b be=%h out=%0d required 1 0 1 1a000080 0 f 0",
               instr_gnt_o, data_gnt_o, mem_req_o, mem_addr_o, mem_we_o, mem_be_o, outstanding_o);
    end
    tick();
    instr_req_i = 1'b0; mem_gnt_i = 1'b0;
    mid();
    tests_run++;
    if (outstanding_o !== CW'(1)) begin
      tests_failed++;
      $display("FAIL fetch_outstanding1: got %0d required 1", outstanding_o);
    end
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0013;
    mid();
    tests_run++;
    if ({instr_rvalid_o, instr_rdata_o, instr_err_o, data_rvalid_o} !== {1'b1, 32'h13, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL fetch_resp: got irv=%b rdata=%h ierr=%b drv=%b required 1 00000013 0 0",
               instr_rvalid_o, instr_rdata_o, instr_err_o, data_rvalid_o);
    end
    tick();
    mem_rvalid_i = 1'b0;
    mid();
    tests_run++;
    if (outstanding_o !== CW'(0)) begin
      tests_failed++;
      $display("FAIL fetch_outstanding0: got %0d required 0", outstanding_o);
    end
    tick();
    $display("[TB] txn fetch addr=1a000080 rdata=00000013");
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] ia, da;
    apply_reset();
    ia = 32'h1A00_0100; da = 32'h0000_2000 | ($urandom & 32'h0000_0FFC);
    instr_req_i = 1'b1; instr_addr_i = ia; data_req_i = 1'b1; data_addr_i = da; mem_gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic dw;
      dw = (k % 2 == 0);
      mem_rvalid_i = (k > 0);
      mid();
      tests_run++;
      if ({data_gnt_o, instr_gnt_o} !== {dw, !dw}) begin
        tests_failed++;
        $display("FAIL rr_grant[%0d]: got dgnt/igat=%b%b required %b%b", k, data_gnt_o, instr_gnt_o, dw, !dw);
      end
      tests_run++;
      if (mem_addr_o !== (dw ? da : ia)) begin
        tests_failed++;
        $display("FAIL rr_addr[%0d]: got %h required %h", k, mem_addr_o, dw ? da : ia);
      end
      if (k > 0) begin
        tests_run++;
        if ({data_rvalid_o, instr_rvalid_o} !== {!dw, dw}) begin
          tests_failed++;
          $display("FAIL rr_steer[%0d]: got drv/irv=%b%b required %b%b", k, data_rvalid_o, instr_rvalid_o, !dw, dw);
        end
      end
      $display("[TB] txn rr grant %0d to %s addr=%h", k, dw ? "DATA" : "INSTR", mem_addr_o);
      tick();
    end
    instr_req_i = 1'b0; data_req_i = 1'b0; mem_rvalid_i = 1'b1;
    mid();
    tests_run++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin
      tests_failed++;
      $display("FAIL rr_drain: got irv/drv=%b%b required 10", instr_rvalid_o, data_rvalid_o);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_lock_hold();
    logic [DW-1:0] wd;
    apply_reset();
    data_req_i = 1'b1; data_addr_i = 32'h40; mem_gnt_i = 1'b1;
    tick();
    data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    wd = $urandom;
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0011; data_addr_i = 32'h100; data_wdata_i = wd;
    instr_addr_i = 32'h1A00_0200;
    for (int k = 0; k < 4; k++) begin
      instr_req_i = (k > 0);
      mem_gnt_i = (k == 3);
      mid();
      tests_run++;
      if ({mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== {1'b1, 32'h100, 1'b1, 4'b0011, wd}) begin
        tests_failed++;
        $display("FAIL lock_bus[%0d]: got req=%b addr=%h we=%b be=%b wdata=%h required 1 00000100 1 0011 %h",
                 k, mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, wd);
      end
      tests_run++;
      if ({instr_gnt_o, data_gnt_o} !== {1'b0, (k == 3)}) begin
        tests_failed++;
        $display("FAIL lock_gnt[%0d]: got igat/dgnt=%b%b required 0%b", k, instr_gnt_o, data_gnt_o, (k == 3));
      end
      tick();
    end
    $display("[TB] txn data write addr=00000100 be=0011 wdata=%h", wd);
    data_req_i = 1'b0; data_we_i = 1'b0; mem_gnt_i = 1'b1;
    mid();
    tests_run++;
    if ({instr_gnt_o, mem_addr_o, outstanding_o} !== {1'b1, 32'h1A00_0200, CW'(1)}) begin
      tests_failed++;
      $display("FAIL lock_release: got igat=%b addr=%h out=%0d required 1 1a000200 1",
               instr_gnt_o, mem_addr_o, outstanding_o);
    end
    tick();
    instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mid();
      tests_run++;
      if ({data_rvalid_o, instr_rvalid_o} !== {(k == 0), (k == 1)}) begin
        tests_failed++;
        $display("FAIL lock_order[%0d]: got drv/irv=%b%b required %b%b", k, data_rvalid_o, instr_rvalid_o, (k == 0), (k == 1));
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_full();
    apply_reset();
    instr_req_i = 1'b1; instr_addr_i = 32'h1A00_0300; mem_gnt_i = 1'b1;
    mid();
    tests_run++;
    if (instr_gnt_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_first: got igat=%b required 1", instr_gnt_o);
    end
    tick();
    instr_req_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h200;
    mid();
    tests_run++;
    if ({data_gnt_o, outstanding_o} !== {1'b1, CW'(1)}) begin
      tests_failed++;
      $display("FAIL full_second: got dgnt=%b out=%0d required 1 1", data_gnt_o, outstanding_o);
    end
    tick();
    mid();
    tests_run++;
    if ({mem_req_o, data_gnt_o, outstanding_o} !== {1'b0, 1'b0, CW'(2)}) begin
      tests_failed++;
      $display("FAIL full_block: got req=%b dgnt=%b out=%0d required 0 0 2", mem_req_o, data_gnt_o, outstanding_o);
    end
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA_0001;
    mid();
    tests_run++;
    if ({mem_req_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, instr_rdata_o} !==
        {1'b0, 1'b0, 1'b1, 1'b0, 32'hAAAA_0001}) begin
      tests_failed++;
      $display("FAIL full_pop_no_push: got req=%b dgnt=%b irv=%b drv=%b rdata=%h required 0 0 1 0 aaaa0001",
               mem_req_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, instr_rdata_o);
    end
    tick();
    mem_rdata_i = 32'hBBBB_0002;
    mid();
    tests_run++;
    if ({mem_req_o, data_gnt_o, data_rvalid_o, instr_rvalid_o, data_rdata_o} !==
        {1'b1, 1'b1, 1'b1, 1'b0, 32'hBBBB_0002}) begin
      tests_failed++;
      $display("FAIL full_unblock: got req=%b dgnt=%b drv=%b irv=%b rdata=%h required 1 1 1 0 bbbb0002",
               mem_req_o, data_gnt_o, data_rvalid_o, instr_rvalid_o, data_rdata_o);
    end
    tick();
    data_req_i = 1'b0;
    mid();
    tests_run++;
    if ({data_rvalid_o, outstanding_o} !== {1'b1, CW'(1)}) begin
      tests_failed++;
      $display("FAIL full_last_resp: got drv=%b out=%0d required 1 1", data_rvalid_o, outstanding_o);
    end
    tick();
    mem_rvalid_i = 1'b0;
    mid();
    tests_run++;
    if (outstanding_o !== CW'(0)) begin
      tests_failed++;
      $display("FAIL full_drained: got %0d required 0", outstanding_o);
    end
    tick();
    idle_inputs();
    $display("[TB] txn full: 3 data/instr transactions completed in order");
  endtask

  task automatic test_proto_err();
    apply_reset();
    mem_rvalid_i = 1'b1; mem_err_i = 1'b1;
    mid();
    tests_run++;
    if ({instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o, proto_err_o} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL proto_drop: got irv/drv/ierr/derr/proto=%b required 00000",
               {instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o, proto_err_o});
    end
    tick();
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mid();
      tests_run++;
      if ({proto_err_o, outstanding_o} !== {1'b1, CW'(0)}) begin
        tests_failed++;
        $display("FAIL proto_sticky[%0d]: got proto=%b out=%0d required 1 0", k, proto_err_o, outstanding_o);
      end
      tick();
    end
    $display("[TB] txn stray rvalid flagged");
  endtask

  task automatic test_async_reset();
    apply_reset();
    instr_req_i = 1'b1; instr_addr_i = 32'h1A00_0400; mem_gnt_i = 1'b1;
    tick();
    instr_req_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h300;
    tick();
    instr_req_i = 1'b1;
    mid();
    tests_run++;
    if (outstanding_o !== CW'(2)) begin
      tests_failed++;
      $display("FAIL areset_pre: got out=%0d required 2", outstanding_o);
    end
    #2;
    reset = 1'b1; mem_rvalid_i = 1'b1;
    #1;
    tests_run++;
    if ({outstanding_o, mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o} !== {CW'(0), 5'b00000}) begin
      tests_failed++;
      $display("FAIL areset_immediate: got out=%0d req=%b igat=%b dgnt=%b irv=%b drv=%b required all 0",
               outstanding_o, mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o);
    end
    tick();
    idle_inputs();
    reset = 1'b0;
    mem_rvalid_i = 1'b1;
    mid();
    tests_run++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin
      tests_failed++;
      $display("FAIL areset_discard: got irv/drv=%b%b required 00", instr_rvalid_o, data_rvalid_o);
    end
    tick();
    mem_rvalid_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'h1A00_0500; mem_gnt_i = 1'b1;
    mid();
    tests_run++;
    if ({proto_err_o, instr_gnt_o} !== 2'b11) begin
      tests_failed++;
      $display("FAIL areset_after: got proto=%b igat=%b required 1 1", proto_err_o, instr_gnt_o);
    end
    tick();
    idle_inputs();
    $display("[TB] txn async reset discarded 2 in-flight");
  endtask

  // Reference model: in-order queue of issuers, a held request that must be served first,
  // alternation between simultaneous requesters, and a sticky flag for unmatched responses.
  task automatic test_random();
    bit q[$];
    bit last_o, pend_v, pend_o, proto;
    apply_reset();
    last_o = 1'b0; pend_v = 1'b0; pend_o = 1'b0; proto = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      bit own, own_req, full, e_req, e_ig, e_dg, e_irv, e_drv;
      logic [AW+DW+DW/8:0] exp_bus;
      mem_gnt_i = ($urandom_range(0, 3) != 0);
      if (q.size() > 0) mem_rvalid_i = ($urandom_range(0, 2) == 0);
      else              mem_rvalid_i = ($urandom_range(0, 31) == 0);
      mem_rdata_i = $urandom;
      mem_err_i = ($urandom_range(0, 7) == 0);
      full = (q.size() == MAXO);
      if (pend_v)                          own = pend_o;
      else if (instr_req_i && !data_req_i) own = 1'b0;
      else if (data_req_i && !instr_req_i) own = 1'b1;
      else                                 own = !last_o;
      own_req = own ? data_req_i : instr_req_i;
      e_req = own_req && !full;
      e_ig = e_req && mem_gnt_i && !own;
      e_dg = e_req && mem_gnt_i && own;
      e_irv = 1'b0; e_drv = 1'b0;
      if (mem_rvalid_i && q.size() > 0) begin
        e_irv = (q[0] == 1'b0);
        e_drv = (q[0] == 1'b1);
      end
      mid();
      tests_run++;
      if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o,
           outstanding_o, proto_err_o} !==
          {e_req, e_ig, e_dg, e_irv, e_drv, e_irv && mem_err_i, e_drv && mem_err_i, CW'(q.size()), proto}) begin
        tests_failed++;
        $display("FAIL rand_ctrl[%0d]: got req/ig/dg/irv/drv/ierr/derr=%b out=%0d proto=%b required %b out=%0d proto=%b",
                 cyc, {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o},
                 outstanding_o, proto_err_o,
                 {e_req, e_ig, e_dg, e_irv, e_drv, e_irv && mem_err_i, e_drv && mem_err_i}, q.size(), proto);
      end
      if (e_req) begin
        exp_bus = own ? {data_addr_i, data_we_i, data_be_i, data_wdata_i}
                      : {instr_addr_i, 1'b0, {(DW/8){1'b1}}, {DW{1'b0}}};
        tests_run++;
        if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== exp_bus) begin
          tests_failed++;
          $display("FAIL rand_bus[%0d]: got addr/we/be/wdata=%h required %h",
                   cyc, {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o}, exp_bus);
        end
      end
      if (e_irv || e_drv) begin
        tests_run++;
        if ((e_irv ? instr_rdata_o : data_rdata_o) !== mem_rdata_i) begin
          tests_failed++;
          $display("FAIL rand_rdata[%0d]: got %h required %h", cyc, e_irv ? instr_rdata_o : data_rdata_o, mem_rdata_i);
        end
      end
      if (e_ig || e_dg)
        $display("[TB] txn rand cycle %0d grant %s addr=%h", cyc, own ? "DATA" : "INSTR", mem_addr_o);
      if (mem_rvalid_i) begin
        if (q.size() > 0) void'(q.pop_front());
        else              proto = 1'b1;
      end
      if (e_req && mem_gnt_i) begin
        q.push_back(own);
        last_o = own;
        pend_v = 1'b0;
      end else if (e_req) begin
        pend_v = 1'b1;
        pend_o = own;
      end
      tick();
      if (e_ig || !instr_req_i) begin
        instr_req_i = ($urandom_range(0, 1) == 1);
        instr_addr_i = $urandom & 32'hFFFF_FFFC;
      end
      if (e_dg || !data_req_i) begin
        data_req_i = ($urandom_range(0, 1) == 1);
        data_we_i = $urandom_range(0, 1) == 1;
        data_be_i = 4'($urandom);
        data_addr_i = $urandom & 32'hFFFF_FFFC;
        data_wdata_i = $urandom;
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_lock_hold();
    test_full();
    test_proto_err();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
